// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_pkg
// Purpose : Shared definitions for the store path. Holds the store_control
//           encodings produced by the decode stage, the store FSM state type,
//           and helper functions for lane-mask and alignment decode.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package riscv_pkg;

    // store_control encodings; codes 3..7 behave as SB
    localparam logic [2:0] STORE_SB = 3'd0;
    localparam logic [2:0] STORE_SH = 3'd1;
    localparam logic [2:0] STORE_SW = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ_LO = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_ERR    = 2'd3
    } store_state_e;

    // Byte-enable pattern of the store before it is shifted into its lanes.
    function automatic logic [3:0] store_base_mask(input logic [2:0] ctrl);
        logic [3:0] mask;
        case (ctrl)
            STORE_SH: mask = 4'b0011;
            STORE_SW: mask = 4'b1111;
            default:  mask = 4'b0001;
        endcase
        return mask;
    endfunction

    // True when a halfword/word store is not naturally aligned.
    function automatic logic store_misaligned(input logic [2:0] ctrl,
                                              input logic [1:0] off);
        logic mis;
        case (ctrl)
            STORE_SH: mis = off[0];
            STORE_SW: mis = (off != 2'b00);
            default:  mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/store_align.sv
`default_nettype none
// ============================================================================
// Module  : store_align
// Purpose : Purely combinational lane alignment for one store. Produces the
//           8-bit byte-enable span (low word in [3:0], next word in [7:4])
//           and the 64-bit lane-positioned data. Bytes outside the store
//           width are zeroed so unused lanes of either word read as 0.
// Ports   : off[1:0]          byte offset of the effective address
//           store_control[2:0] SB/SH/SW selector
//           rs2_data[31:0]    raw store data
//           m8[7:0]           shifted byte-enable span
//           d64[63:0]         shifted store data
// Revision: 1.0  initial release
// ============================================================================
module store_align
    import riscv_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  store_control,
    input  logic [31:0] rs2_data,
    output logic [7:0]  m8,
    output logic [63:0] d64
);

    logic [3:0]  w_base;
    logic [31:0] w_data_masked;

    always_comb begin
        w_base        = store_base_mask(store_control);
        // Keep only the bytes the store actually writes.
        w_data_masked = rs2_data & {{8{w_base[3]}}, {8{w_base[2]}},
                                    {8{w_base[1]}}, {8{w_base[0]}}};
        m8            = {4'b0000, w_base} << off;
        d64           = {32'h0000_0000, w_data_masked} << {off, 3'b000};
    end

endmodule : store_align
`default_nettype wire

// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module  : store_unit
// Purpose : Executes one decoded store per transaction. Forms the effective
//           address rs1_data + sext(imm), builds byte-lane write data and
//           enables, and drives a req/ack handshake to the data memory.
//           Word-crossing stores are split into two back-to-back accesses
//           when STORE_SPLIT_EN is defined; otherwise every non-naturally-
//           aligned SH/SW is rejected with st_done+st_err.
// Config  : `define STORE_SPLIT_EN  -> enable split of word-crossing stores
// Ports   : clk, rst (async, active-high)
//           st_valid/st_ready          store handshake from decode
//           rs1_data, rs2_data, imm, store_control  store operands
//           mem_req/mem_ack            memory handshake
//           mem_addr, mem_wdata, mem_be  word-aligned access
//           st_done, st_err            registered completion pulses
// Revision: 1.0  initial release
// ============================================================================
module store_unit
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [11:0] imm,
    input  logic [2:0]  store_control,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        st_done,
    output logic        st_err
);

    // ------------------------------------------------------------------
    // Effective address and lane alignment of the presented store
    // ------------------------------------------------------------------
    logic [31:0] w_ea;
    logic [7:0]  w_m8;
    logic [63:0] w_d64;
    logic        w_accept;
    logic        w_reject;

    assign w_ea = rs1_data + {{20{imm[11]}}, imm};

    store_align u_store_align (
        .off           (w_ea[1:0]),
        .store_control (store_control),
        .rs2_data      (rs2_data),
        .m8            (w_m8),
        .d64           (w_d64)
    );

`ifdef STORE_SPLIT_EN
    assign w_reject = 1'b0;
`else
    assign w_reject = store_misaligned(store_control, w_ea[1:0]);
`endif

    // ------------------------------------------------------------------
    // State and operand registers
    // ------------------------------------------------------------------
    store_state_e state_q, state_d;
    logic [31:0]  mem_addr_q, mem_addr_d;
    logic [31:0]  mem_wdata_q, mem_wdata_d;
    logic [3:0]   mem_be_q, mem_be_d;
    logic [31:0]  hi_wdata_q, hi_wdata_d;
    logic [3:0]   hi_be_q, hi_be_d;
    logic         need_hi_q, need_hi_d;
    logic         st_done_q, st_done_d;
`ifndef STORE_SPLIT_EN
    logic         st_err_q, st_err_d;
`endif

    assign w_accept = st_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        hi_wdata_d  = hi_wdata_q;
        hi_be_d     = hi_be_q;
        need_hi_d   = need_hi_q;
        st_done_d   = 1'b0;
`ifndef STORE_SPLIT_EN
        st_err_d    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_reject) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d     = ST_REQ_LO;
                        mem_addr_d  = {w_ea[31:2], 2'b00};
                        mem_be_d    = w_m8[3:0];
                        mem_wdata_d = w_d64[31:0];
                        // The second word is only touched when the shifted
                        // enable span spills past lane 3.
                        hi_be_d     = w_m8[7:4];
                        hi_wdata_d  = w_d64[63:32];
                        need_hi_d   = |w_m8[7:4];
                    end
                end
            end

            ST_REQ_LO: begin
                if (mem_ack) begin
                    if (need_hi_q) begin
                        // Next word; 32-bit add wraps 0xFFFFFFFC to 0.
                        state_d     = ST_REQ_HI;
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_be_d    = hi_be_q;
                        mem_wdata_d = hi_wdata_q;
                    end else begin
                        state_d   = ST_IDLE;
                        st_done_d = 1'b1;
                    end
                end
            end

            ST_REQ_HI: begin
                if (mem_ack) begin
                    state_d   = ST_IDLE;
                    st_done_d = 1'b1;
                end
            end

            ST_ERR: begin
                state_d   = ST_IDLE;
                st_done_d = 1'b1;
`ifndef STORE_SPLIT_EN
                st_err_d  = 1'b1;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_be_q    <= 4'b0000;
            hi_wdata_q  <= 32'h0000_0000;
            hi_be_q     <= 4'b0000;
            need_hi_q   <= 1'b0;
            st_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            hi_wdata_q  <= hi_wdata_d;
            hi_be_q     <= hi_be_d;
            need_hi_q   <= need_hi_d;
            st_done_q   <= st_done_d;
        end
    end

`ifndef STORE_SPLIT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_err_q <= 1'b0;
        end else begin
            st_err_q <= st_err_d;
        end
    end
    assign st_err = st_err_q;
`else
    assign st_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs. mem_req decodes straight from the state register so the
    // asynchronous reset drops it immediately.
    // ------------------------------------------------------------------
    assign st_ready  = (state_q == ST_IDLE);
    assign mem_req   = (state_q == ST_REQ_LO) || (state_q == ST_REQ_HI);
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign st_done   = st_done_q;

endmodule : store_unit
`default_nettype wire

// File: doc/store_unit.md
# store_unit

Executes one decoded store per transaction: forms the effective address from the base register value and the 12-bit store immediate, builds a byte-lane write with byte enables, and drives a req/ack handshake to the data-memory port. Sits directly downstream of the store-instruction decode stage, consuming its `imm` and `store_control`, plus the register-file read data for `rs1` and `rs2`. Stores that cross a word boundary are either split into two word accesses or rejected, depending on the build configuration.

## Interface
Parameters: none. The data and address widths are fixed at 32.

- `clk`  in  1  single clock, all state on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `st_valid`  in  1  upstream presents a store.
- `st_ready`  out  1  block can accept a store; high only in IDLE.
- `rs1_data`  in  32  base address value.
- `rs2_data`  in  32  store data value.
- `imm`  in  12  store offset, signed.
- `store_control`  in  3  SB=0, SH=1, SW=2; codes 3..7 are treated as SB.
- `mem_req`  out  1  memory request.
- `mem_addr`  out  32  word-aligned address, bits [1:0]=0.
- `mem_wdata`  out  32  lane-positioned write data.
- `mem_be`  out  4  byte enables; bit i enables `mem_wdata[8i+7:8i]`.
- `mem_ack`  in  1  memory accepted the current request.
- `st_done`  out  1  one-cycle pulse when the store completes.
- `st_err`  out  1  one-cycle pulse together with `st_done` on a rejected misaligned store.

## Operation
- Effective address: `ea = rs1_data + sext(imm)`, computed modulo 2^32. `off = ea[1:0]`.
- Base mask: SB=4'b0001, SH=4'b0011, SW=4'b1111.
- 8-bit mask: `m8 = base << off`.
- 64-bit data: `d64 = zext(rs2_data) << 8*off`.
- Low access:
  - `mem_addr = {ea[31:2],2'b00}`
  - `mem_be = m8[3:0]`
  - `mem_wdata = d64[31:0]`
- High access, only if `m8[7:4] != 0`:
  - `mem_addr = low address + 4`, wrapping 0xFFFFFFFC → 0x00000000.
  - `mem_be = m8[7:4]`
  - `mem_wdata = d64[63:32]`
- Unused byte lanes of `mem_wdata` are 0.
- Operands are captured when `st_valid && st_ready`. Inputs are don't-care at all other times.

State machine:
- **IDLE**
  - `st_ready = 1`.
  - On accept, go to REQ_LO.
  - With `STORE_SPLIT_EN` undefined and the store misaligned, go to ERR instead. Misaligned means SH with `off[0]=1`, or SW with `off != 0`.
- **REQ_LO**
  - `mem_req = 1`.
  - On `mem_ack`: go to REQ_HI if a high access is needed, else to IDLE.
- **REQ_HI**
  - `mem_req = 1`.
  - On `mem_ack`, go to IDLE.
- **ERR**
  - No request is issued.
  - Next state is IDLE.
- `st_done` is registered. It is high for exactly one cycle after the final `mem_ack`, or after ERR.
- `st_err` is high only in the cycle `st_done` is high following ERR.

## Timing
- Reset values:
  - State = IDLE, so `st_ready = 1`.
  - `mem_req = 0`, `mem_addr = 0`, `mem_wdata = 0`, `mem_be = 0`, `st_done = 0`, `st_err = 0`.
- Reset mid-transaction drops `mem_req` asynchronously. The in-flight store is abandoned with no `st_done`.
- Accept at edge N:
  - `mem_req` is high during cycle N+1.
  - With `mem_ack` in N+1, `st_done = 1` and `st_ready = 1` in cycle N+2.
  - A new store may be accepted at the end of N+2.
- Split store with immediate acks: `st_done` is high in cycle N+3.
- While `mem_req = 1`, `mem_addr`, `mem_wdata` and `mem_be` are held stable until `mem_ack`. Memory wait states are unbounded.
- `mem_ack` is ignored while `mem_req = 0`.
- The lo→hi transition is back-to-back: REQ_HI is entered on the edge of the low `mem_ack`.

## Configuration
- `STORE_SPLIT_EN` defined:
  - Boundary-crossing SH/SW are performed as two accesses.
  - Misaligned stores within a word use a single access.
  - `st_err` is tied to 0 and the ERR state is absent.
- `STORE_SPLIT_EN` undefined:
  - Every non-naturally-aligned SH/SW is rejected through ERR; REQ_HI is unreachable.
  - SB is never rejected.

## Structure
- Shared package `riscv_pkg` holds:
  - the SB/SH/SW store_control constants used by the decode stage;
  - the store FSM state enum (IDLE, REQ_LO, REQ_HI, ERR).
- Sub-module `store_align`: purely combinational; `ea` and `store_control` → `m8`; `rs2_data` and `off` → `d64`.
- `store_unit` owns the operand registers, FSM and output registers.

## Test plan
- SW, rs1=0x1000, imm=0x004, rs2=0xDEADBEEF, ack in next cycle:
  - one request: addr=0x1004, be=1111, wdata=0xDEADBEEF;
  - `st_done` 2 cycles after accept.
- SB, rs1=0x1003, imm=0xFFF (-1), rs2=0x000000A5:
  - addr=0x1000, be=0100, wdata=0x00A50000.
- SH, ea=0x2003, rs2=0x1234, split on:
  - first request addr=0x2000, be=1000, wdata=0x34000000;
  - then addr=0x2004, be=0001, wdata=0x00000012;
  - `st_done` once.
- Same store as above, split off:
  - no `mem_req`;
  - `st_done=1` and `st_err=1` in cycle N+2;
  - `st_ready` high again.
- SW, ea=0xFFFFFFFE, rs2=0xAABBCCDD, split on, 3 wait cycles per access:
  - addr=0xFFFFFFFC, be=1100, wdata=0xCCDD0000, held stable through waits;
  - then addr=0x00000000, be=0011, wdata=0x0000AABB.
- Assert `rst` during REQ_LO wait:
  - `mem_req` falls immediately;
  - no `st_done`;
  - after release, `st_ready=1` and the next store proceeds normally.
